// File: rtl/mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_responder                                                            |
// | Byte-enabled on-chip line memory with fixed-latency in-order read        |
// | responses and credit-limited outstanding reads.                          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_responder #(
  parameter int DATA_WIDTH   = 512,
  parameter int ADDR_WIDTH   = 26,
  parameter int TAG_WIDTH    = 8,
  parameter int BYTEEN_WIDTH = DATA_WIDTH / 8,
  parameter int SIZE_BITS    = 10,
  parameter int LATENCY      = 4,
  parameter int QUEUE_SIZE   = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mem_req_valid,
  input  logic                    mem_req_rw,
  input  logic [BYTEEN_WIDTH-1:0] mem_req_byteen,
  input  logic [ADDR_WIDTH-1:0]   mem_req_addr,
  input  logic [DATA_WIDTH-1:0]   mem_req_data,
  input  logic [TAG_WIDTH-1:0]    mem_req_tag,
  output logic                    mem_req_ready,
  output logic                    mem_rsp_valid,
  output logic [DATA_WIDTH-1:0]   mem_rsp_data,
  output logic [TAG_WIDTH-1:0]    mem_rsp_tag,
  input  logic                    mem_rsp_ready,
  output logic                    busy
);

  localparam int PW = $clog2(QUEUE_SIZE) + 1;
  localparam int QAW = $clog2(QUEUE_SIZE);
  localparam int DL = LATENCY - 1;
  localparam logic [PW-1:0] QS_CNT = PW'(QUEUE_SIZE);

  logic [DATA_WIDTH-1:0] mem [2**SIZE_BITS];
  logic [SIZE_BITS-1:0]  idx;
  logic                  wr_fire;
  logic                  rd_fire;
  logic                  pop;
  logic                  push;
  logic [PW-1:0]         pending;
  logic                  unused_addr_bits;

  assign idx              = mem_req_addr[SIZE_BITS-1:0];
  assign unused_addr_bits = ^mem_req_addr[ADDR_WIDTH-1:SIZE_BITS];
  assign mem_req_ready    = !reset && (pending < QS_CNT);
  assign wr_fire          = mem_req_valid && mem_req_ready && mem_req_rw;
  assign rd_fire          = mem_req_valid && mem_req_ready && !mem_req_rw;
  assign busy             = (pending != '0);

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int i = 0; i < BYTEEN_WIDTH; i++) begin
        if (mem_req_byteen[i]) begin
          mem[idx][i*8 +: 8] <= mem_req_data[i*8 +: 8];
        end
      end
    end
  end

  // Credits cover both the delay line and the FIFO, so the FIFO never overflows.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
    end else begin
      case ({rd_fire, pop})
        2'b10:   pending <= pending + PW'(1);
        2'b01:   pending <= pending - PW'(1);
        default: pending <= pending;
      endcase
    end
  end

  logic [DL-1:0]         dl_valid;
  logic [DATA_WIDTH-1:0] dl_data [DL];
  logic [TAG_WIDTH-1:0]  dl_tag  [DL];

  always_ff @(posedge clk) begin
    if (reset) begin
      dl_valid <= '0;
    end else begin
      dl_valid[0] <= rd_fire;
      for (int i = 1; i < DL; i++) begin
        dl_valid[i] <= dl_valid[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    dl_data[0] <= mem[idx];
    dl_tag[0]  <= mem_req_tag;
    for (int i = 1; i < DL; i++) begin
      dl_data[i] <= dl_data[i-1];
      dl_tag[i]  <= dl_tag[i-1];
    end
  end

  logic [DATA_WIDTH-1:0] q_data [QUEUE_SIZE];
  logic [TAG_WIDTH-1:0]  q_tag  [QUEUE_SIZE];
  logic [QAW-1:0]        wr_ptr;
  logic [QAW-1:0]        rd_ptr;
  logic [PW-1:0]         count;
  logic                  fifo_full;

  assign push          = dl_valid[DL-1];
  assign pop           = mem_rsp_valid && mem_rsp_ready;
  assign fifo_full     = (count == QS_CNT);
  assign mem_rsp_valid = (count != '0);
  assign mem_rsp_data  = q_data[rd_ptr];
  assign mem_rsp_tag   = q_tag[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + QAW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + QAW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + PW'(1);
        2'b01:   count <= count - PW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_data[wr_ptr] <= dl_data[DL-1];
      q_tag[wr_ptr]  <= dl_tag[DL-1];
    end
  end

  a_no_full_with_inflight: assert property (@(posedge clk) disable iff (reset)
    !(fifo_full && (|dl_valid)));

endmodule
`default_nettype wire

// File: doc/mem_responder.md
# mem_responder

Synchronous memory-side responder for the Vortex top-level memory interface. It accepts the request stream the processor issues (`mem_req_*`) and returns read data on `mem_rsp_*`. Backing storage is an on-chip byte-enabled array. Reads have a fixed, configurable latency and an in-order response queue with credit-based backpressure. It serves as the RTL-simulation memory behind the top level and as a small scratch memory in FPGA builds.

## Interface
- DATA_WIDTH, 512, bits per memory line (the `VX_MEM_DATA_WIDTH` value).
- ADDR_WIDTH, 26, line address width (the `VX_MEM_ADDR_WIDTH` value).
- TAG_WIDTH, 8, request/response tag width (the `VX_MEM_TAG_WIDTH` value).
- BYTEEN_WIDTH, DATA_WIDTH/8, byte-enable width.
- SIZE_BITS, 10, log2 of lines stored; index = `mem_req_addr[SIZE_BITS-1:0]`, upper bits ignored.
- LATENCY, 4, read accept-to-response cycles; legal range ≥ 2.
- QUEUE_SIZE, 8, maximum outstanding reads; power of 2, ≥ 2.

Ports:
- clk  in  1  clock.
- reset  in  1  reset; one clock, synchronous, active-high.
- mem_req_valid  in  1  request valid.
- mem_req_rw  in  1  1 = write, 0 = read.
- mem_req_byteen  in  BYTEEN_WIDTH  write byte enables; ignored on reads.
- mem_req_addr  in  ADDR_WIDTH  line address.
- mem_req_data  in  DATA_WIDTH  write data.
- mem_req_tag  in  TAG_WIDTH  tag; returned unchanged with the read response.
- mem_req_ready  out  1  request accepted when valid && ready.
- mem_rsp_valid  out  1  read response valid.
- mem_rsp_data  out  DATA_WIDTH  read data.
- mem_rsp_tag  out  TAG_WIDTH  tag of the read being answered.
- mem_rsp_ready  in  1  consumer accepts when valid && ready.
- busy  out  1  at least one read outstanding.

## Operation
- **Outstanding counter.** `pending` has width log2(QUEUE_SIZE)+1 and counts reads in the delay line plus reads in the response queue.
  - +1 on read accept; −1 on response fire.
  - Both in the same cycle: unchanged.
  - Never exceeds QUEUE_SIZE, never underflows.
- **mem_req_ready** = !reset && (pending < QUEUE_SIZE).
  - Registered-state function only; never depends on mem_req_valid.
  - Writes are gated by the same ready.
- **Write accept.** On the clock edge, each byte i with byteen[i]=1 is updated at index addr; other bytes are untouched. Writes produce no response and do not change `pending`.
- **Read accept.** Array data at index addr is sampled at the accept edge.
  - A write accepted in an earlier cycle is visible.
  - Only one request is accepted per cycle, so read/write collision cannot occur.
- **Delay line.** Shift register of {valid, data, tag}, advancing every cycle unconditionally. Its output enters a QUEUE_SIZE-deep FIFO.
  - The FIFO cannot overflow because of the credit rule above.
- **Response.** FIFO head drives mem_rsp_valid, mem_rsp_data and mem_rsp_tag. Pop on mem_rsp_valid && mem_rsp_ready.
  - Responses are strictly in accept order.
  - Data and tag hold stable while valid && !ready.
- **busy** = (pending != 0).
- **Reset.** Clears delay-line valids, the FIFO pointers/count and `pending`. Array contents are NOT reset.
  - Reset mid-operation drops all in-flight reads; no response for them ever appears.

## Timing
- Reset values:
  - mem_req_ready = 0 during reset, 1 in the first cycle after reset.
  - mem_rsp_valid = 0, busy = 0.
  - mem_rsp_data / mem_rsp_tag are don't-care while mem_rsp_valid = 0.
- Read accepted in cycle T, empty FIFO, mem_rsp_ready held 1: mem_rsp_valid asserts in cycle T+LATENCY exactly.
- Back-to-back reads accepted in T, T+1, …: responses appear in T+LATENCY, T+LATENCY+1, …, giving sustained throughput of 1 read per cycle.
- Write accepted in T is visible to a read accepted in T+1.
- With pending = QUEUE_SIZE−1:
  - A read accept with no pop drives ready to 0 the next cycle.
  - A pop in the same cycle as the accept keeps ready at 1.
- With ready = 0, the first pop re-raises ready in the following cycle.
- FIFO full while the delay line is nonempty is impossible; an assertion fires if it ever occurs.

## Test plan
- **Write/read.** Write addr 0x10, data pattern A, byteen all-ones; read 0x10 with tag 0x5A → response data A, tag 0x5A, exactly LATENCY cycles after accept.
- **Byte enables.** Write 0x20 all-0x00; write 0xFF with byteen 0x0F…0F; read 0x20 → bytes with enable set = 0xFF, others = 0x00.
- **Backpressure.** Hold mem_rsp_ready=0 and issue 9 reads (tags 0..8) → first 8 accepted, mem_req_ready=0 on the 9th, busy=1. Release mem_rsp_ready → tags 0..7 return in order; tag 8 is accepted one cycle after the first pop.
- **Streaming.** 32 back-to-back reads with mem_rsp_ready=1 → one response per cycle, mem_req_ready never deasserts, in-order tags.
- **Simultaneous events.** At pending=QUEUE_SIZE−1, accept a read and pop a response in the same cycle → pending unchanged, ready stays 1.
- **Reset mid-operation.** 3 reads in flight, reset for 1 cycle → no responses afterward, busy=0, ready=1; array data written before the reset reads back intact.
